// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small write FIFO.
//   Programmable bit period (CLKS_PER_BIT), data width (DATA_BITS, LSB first),
//   1 or 2 stop bits, and back-to-back frames with no idle gap.
//   Optional parity bit when the macro UART_TX_PARITY_EN is defined.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   en            allows new frames to start
//   wr, wr_data   push strobe and data (accepted when !full)
//   full, empty   FIFO status from the registered entry count
//   overflow      1-cycle pulse after a write was dropped because the FIFO was full
//   out           serial line, idles high
//   busy          high while a frame is on the line
//   done          1-cycle pulse after each frame's stop period
//   parity_odd    (UART_TX_PARITY_EN only) 1 = odd parity, 0 = even parity
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wr,
    input  logic [DATA_BITS-1:0] wr_data,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 out,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        w_count_next;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_overflow;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_can_pop;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    state_t               r_state;
    state_t               w_state_next;
    logic [BW-1:0]        r_baud;
    logic [BW-1:0]        w_baud_next;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 r_par;
    logic                 w_par_next;
    logic                 w_tc;
    logic                 r_out;
    logic                 w_out_next;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_done_next;

    // FIFO bookkeeping; a write while full is dropped even if a pop happens that cycle
    assign w_push       = wr && !r_full;
    assign w_can_pop    = en && !r_empty;
    assign w_head       = r_mem[r_rptr];
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

`ifdef UART_TX_PARITY_EN
    assign w_head_par = (^w_head) ^ parity_odd;
`else
    assign w_head_par = 1'b0;
`endif

    // FIFO storage; contents are don't-care after reset since pointers clear
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // FIFO pointers, count and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count    <= w_count_next;
            r_full     <= (w_count_next == CW'(FIFO_DEPTH));
            r_empty    <= (w_count_next == '0);
            r_overflow <= wr && r_full;
        end
    end

    assign w_tc = (r_baud == BW'(CLKS_PER_BIT - 1));

    // Next state; line level is derived from the next state so out is registered
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = w_tc ? '0 : r_baud + BW'(1);
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        w_pop        = 1'b0;
        w_done_next  = 1'b0;
        w_out_next   = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                w_idx_next  = '0;
                if (w_can_pop) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_par_next   = w_head_par;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_tc) begin
                    w_idx_next   = '0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tc) begin
                    if (r_idx == IW'(DATA_BITS - 1)) begin
                        w_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_idx_next = r_idx + IW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tc) begin
                    w_idx_next   = '0;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // r_idx counts stop bits here
                if (w_tc) begin
                    if (r_idx == IW'(STOP_BITS - 1)) begin
                        w_done_next = 1'b1;
                        w_idx_next  = '0;
                        if (w_can_pop) begin
                            w_pop        = 1'b1;
                            w_shift_next = w_head;
                            w_par_next   = w_head_par;
                            w_state_next = S_START;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_idx_next = r_idx + IW'(1);
                    end
                end
            end
            default: begin
                w_baud_next  = '0;
                w_idx_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase

        case (w_state_next)
            S_START:  w_out_next = 1'b0;
            S_DATA:   w_out_next = w_shift_next[w_idx_next];
            S_PARITY: w_out_next = w_par_next;
            default:  w_out_next = 1'b1;
        endcase
    end

    // FSM state and registered line outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_out   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_par   <= w_par_next;
            r_out   <= w_out_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= w_done_next;
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign overflow = r_overflow;
    assign out      = r_out;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: bench for uart_tx_fifo (8 data bits, 4 clk/bit, 1 stop bit, depth 4)
// plus a second instance with 5 data bits and 2 stop bits. Expected line waveforms
// are built from the frame format and a queue model of FIFO acceptance.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int MAXW  = 512;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L1 = (1 + DB + P + 1) * CPB;
    localparam int L2 = (1 + 5 + P + 2) * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       wr;
    logic [7:0] wr_data;
    logic       full, empty, overflow, out, busy, done;
    logic       parity_odd;
    logic       en2;
    logic       wr2;
    logic [4:0] wr_data2;
    logic       full2, empty2, overflow2, out2, busy2, done2;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .wr_data(wr_data),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .full(full), .empty(empty), .overflow(overflow), .out(out), .busy(busy), .done(done)
    );

    uart_tx_fifo #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .wr(wr2), .wr_data(wr_data2),
`ifdef UART_TX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .full(full2), .empty(empty2), .overflow(overflow2), .out(out2), .busy(busy2), .done(done2)
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [8:0]       q_wr[$];
    logic [8:0]       q_acc[$];
    logic             q_podd[$];
    logic [MAXW-1:0]  lo, lb, ld, lov;
    logic [MAXW-1:0]  e_out, e_busy, e_done, e_ovf;

    function automatic int first_diff(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b);
        for (int i = 0; i < MAXW; i++) if (a[i] !== b[i]) return i;
        return 0;
    endfunction

    // FIFO acceptance for writes on consecutive cycles into an idle transmitter with en=1:
    // the head is popped once, on the first cycle the FIFO is non-empty.
    function automatic void accept_model(input int n);
        int cnt;
        bit popped;
        bit pop;
        cnt = 0;
        popped = 1'b0;
        q_acc.delete();
        q_podd.delete();
        e_ovf = '0;
        for (int i = 0; i < n; i++) begin
            pop = !popped && (cnt > 0);
            if (cnt < DEPTH) begin
                q_acc.push_back(q_wr[i]);
                q_podd.push_back(parity_odd);
                cnt++;
            end else begin
                e_ovf[i] = 1'b1;
            end
            if (pop) begin
                cnt--;
                popped = 1'b1;
            end
        end
    endfunction

    // Expected line: `lead` idle samples, then nfr frames of q_acc back to back, then idle
    function automatic void build_exp(input int lead, input int dbits, input int sbits, input int nfr);
        int t;
        int nbit;
        logic [8:0] b;
        logic pb;
        logic lvl;
        nbit = 1 + dbits + P + sbits;
        e_out = '1;
        e_busy = '0;
        e_done = '0;
        t = lead;
        for (int k = 0; k < nfr; k++) begin
            b = q_acc[k];
            pb = q_podd[k];
            for (int i = 0; i < dbits; i++) pb = pb ^ b[i];
            for (int s = 0; s < nbit; s++) begin
                if (s == 0) lvl = 1'b0;
                else if (s <= dbits) lvl = b[s-1];
                else if (P == 1 && s == dbits + 1) lvl = pb;
                else lvl = 1'b1;
                for (int c = 0; c < CPB; c++) begin
                    e_out[t] = lvl;
                    e_busy[t] = 1'b1;
                    t++;
                end
            end
            e_done[t] = 1'b1;
        end
    endfunction

    task automatic set_wr(input bit sel, input logic v, input logic [8:0] d);
        if (sel) begin
            wr2 = v;
            wr_data2 = d[4:0];
        end else begin
            wr = v;
            wr_data = d[7:0];
        end
    endtask

    task automatic capture(input bit sel, input int win);
        lo = '1; lb = '0; ld = '0; lov = '0;
        for (int t = 0; t < win; t++) begin
            @(negedge clk);
            lo[t]  = sel ? out2 : out;
            lb[t]  = sel ? busy2 : busy;
            ld[t]  = sel ? done2 : done;
            lov[t] = sel ? overflow2 : overflow;
        end
    endtask

    // Writes q_wr[0..n-1] on consecutive cycles; sample 0 is the cycle after the first write
    task automatic run_frames(input bit sel, input int n, input int win);
        @(posedge clk); #1;
        set_wr(sel, 1'b1, q_wr[0]);
        @(posedge clk); #1;
        fork
            begin
                for (int i = 1; i < n; i++) begin
                    set_wr(sel, 1'b1, q_wr[i]);
                    @(posedge clk); #1;
                end
                set_wr(sel, 1'b0, 9'h0);
            end
            capture(sel, win);
        join
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0; wr = 1'b0; wr_data = '0; parity_odd = 1'b0;
        en2 = 1'b1; wr2 = 1'b0; wr_data2 = '0;
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({out, busy, done, overflow, full, empty} !== 6'b100001) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected 100001", {out, busy, done, overflow, full, empty});
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        en = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out, busy, done, overflow, full, empty, out2, busy2, empty2} !== 9'b100001101) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected 100001101",
                     {out, busy, done, overflow, full, empty, out2, busy2, empty2});
        end
    endtask

    task automatic test_single;
        int fd;
        for (int r = 0; r < 3; r++) begin
            q_wr.delete();
            q_wr.push_back((r == 0) ? 9'h0A5 : 9'($urandom_range(0, 255)));
            accept_model(1);
            build_exp(1, DB, 1, q_acc.size());
            run_frames(1'b0, 1, 1 + L1 + 8);
            n_checks++;
            if (lo !== e_out) begin
                n_fail++; fd = first_diff(lo, e_out);
                $display("FAIL single_out[%0d]: sample %0d got %b expected %b", r, fd, lo[fd], e_out[fd]);
            end
            n_checks++;
            if (lb !== e_busy) begin
                n_fail++; fd = first_diff(lb, e_busy);
                $display("FAIL single_busy[%0d]: sample %0d got %b expected %b", r, fd, lb[fd], e_busy[fd]);
            end
            n_checks++;
            if (ld !== e_done) begin
                n_fail++; fd = first_diff(ld, e_done);
                $display("FAIL single_done[%0d]: sample %0d got %b expected %b", r, fd, ld[fd], e_done[fd]);
            end
            n_checks++;
            if (empty !== 1'b1) begin
                n_fail++;
                $display("FAIL single_empty[%0d]: got %b expected 1", r, empty);
            end
        end
    endtask

    task automatic test_back_to_back;
        int fd;
        int n;
        for (int r = 0; r < 3; r++) begin
            q_wr.delete();
            if (r == 0) begin
                q_wr.push_back(9'h000);
                q_wr.push_back(9'h0FF);
                n = 2;
            end else begin
                n = $urandom_range(2, 5);
                for (int i = 0; i < n; i++) q_wr.push_back(9'($urandom_range(0, 255)));
            end
            accept_model(n);
            build_exp(1, DB, 1, q_acc.size());
            run_frames(1'b0, n, 1 + n * L1 + 8);
            n_checks++;
            if (lo !== e_out) begin
                n_fail++; fd = first_diff(lo, e_out);
                $display("FAIL b2b_out[%0d]: sample %0d got %b expected %b", r, fd, lo[fd], e_out[fd]);
            end
            n_checks++;
            if (lb !== e_busy) begin
                n_fail++; fd = first_diff(lb, e_busy);
                $display("FAIL b2b_busy[%0d]: sample %0d got %b expected %b", r, fd, lb[fd], e_busy[fd]);
            end
            n_checks++;
            if (ld !== e_done) begin
                n_fail++; fd = first_diff(ld, e_done);
                $display("FAIL b2b_done[%0d]: sample %0d got %b expected %b", r, fd, ld[fd], e_done[fd]);
            end
        end
    endtask

    task automatic test_overflow;
        int fd;
        for (int n = 6; n <= 7; n++) begin
            q_wr.delete();
            for (int i = 0; i < n; i++) q_wr.push_back(9'($urandom_range(0, 255)));
            accept_model(n);
            build_exp(1, DB, 1, q_acc.size());
            run_frames(1'b0, n, 1 + q_acc.size() * L1 + 8);
            n_checks++;
            if (q_acc.size() != 5 || lov !== e_ovf) begin
                n_fail++; fd = first_diff(lov, e_ovf);
                $display("FAIL ovf_pulse[n=%0d]: sample %0d got %b expected %b (accepted %0d)",
                         n, fd, lov[fd], e_ovf[fd], q_acc.size());
            end
            n_checks++;
            if (lo !== e_out) begin
                n_fail++; fd = first_diff(lo, e_out);
                $display("FAIL ovf_out[n=%0d]: sample %0d got %b expected %b", n, fd, lo[fd], e_out[fd]);
            end
            n_checks++;
            if (ld !== e_done || empty !== 1'b1) begin
                n_fail++; fd = first_diff(ld, e_done);
                $display("FAIL ovf_done[n=%0d]: sample %0d got %b expected %b, empty %b", n, fd, ld[fd], e_done[fd], empty);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        int fd;
        for (int po = 0; po < 2; po++) begin
            parity_odd = po[0];
            q_wr.delete();
            q_wr.push_back(9'h0A5);
            accept_model(1);
            build_exp(1, DB, 1, 1);
            run_frames(1'b0, 1, 1 + L1 + 8);
            n_checks++;
            if (lo[1 + 9 * CPB] !== po[0]) begin
                n_fail++;
                $display("FAIL parity_bit[odd=%0d]: got %b expected %b", po, lo[1 + 9 * CPB], po[0]);
            end
            n_checks++;
            if (lo !== e_out || lb !== e_busy) begin
                n_fail++; fd = first_diff(lo, e_out);
                $display("FAIL parity_frame[odd=%0d]: sample %0d got %b expected %b", po, fd, lo[fd], e_out[fd]);
            end
        end
        parity_odd = 1'b0;
    endtask
`endif

    task automatic test_reset_mid;
        logic [7:0] d0;
        d0 = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        wr = 1'b1; wr_data = d0;
        @(posedge clk); #1;
        wr_data = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        wr = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        n_checks++;
        if ({out, busy, empty} !== {d0[3], 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_before: out/busy/empty got %b expected %b", {out, busy, empty}, {d0[3], 2'b10});
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out, busy, empty} !== 3'b101) begin
            n_fail++;
            $display("FAIL rstmid_async: out/busy/empty got %b expected 101", {out, busy, empty});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q_acc.delete();
        build_exp(0, DB, 1, 0);
        capture(1'b0, 60);
        n_checks++;
        if (lo !== e_out || lb !== e_busy || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_idle: out ones %b, busy zero %b, empty %b expected 1 1 1",
                     lo === e_out, lb === e_busy, empty);
        end
    endtask

    task automatic test_enable;
        int fd;
        logic [8:0] d0, d1;
        en = 1'b0;
        d0 = 9'($urandom_range(0, 255));
        @(posedge clk); #1;
        wr = 1'b1; wr_data = d0[7:0];
        @(posedge clk); #1;
        wr = 1'b0;
        q_acc.delete(); q_podd.delete();
        build_exp(0, DB, 1, 0);
        capture(1'b0, 20);
        n_checks++;
        if (lo !== e_out || lb !== e_busy || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL en_hold: line idle %b, busy low %b, empty %b expected 1 1 0", lo === e_out, lb === e_busy, empty);
        end
        q_acc.push_back(d0); q_podd.push_back(parity_odd);
        build_exp(1, DB, 1, 1);
        @(posedge clk); #1;
        en = 1'b1;
        capture(1'b0, 1 + L1 + 8);
        n_checks++;
        if (lo !== e_out || ld !== e_done) begin
            n_fail++; fd = first_diff(lo, e_out);
            $display("FAIL en_release: sample %0d got %b expected %b", fd, lo[fd], e_out[fd]);
        end
        // two queued frames, en dropped during the first
        en = 1'b0;
        d0 = 9'($urandom_range(0, 255));
        d1 = 9'($urandom_range(0, 255));
        @(posedge clk); #1;
        wr = 1'b1; wr_data = d0[7:0];
        @(posedge clk); #1;
        wr_data = d1[7:0];
        @(posedge clk); #1;
        wr = 1'b0;
        q_acc.delete(); q_podd.delete();
        q_acc.push_back(d0); q_podd.push_back(parity_odd);
        q_acc.push_back(d1); q_podd.push_back(parity_odd);
        build_exp(1, DB, 1, 1);
        @(posedge clk); #1;
        en = 1'b1;
        fork
            capture(1'b0, 1 + 2 * L1 + 8);
            begin
                repeat (10) @(posedge clk);
                #1 en = 1'b0;
            end
        join
        n_checks++;
        if (lo !== e_out || lb !== e_busy || empty !== 1'b0) begin
            n_fail++; fd = first_diff(lo, e_out);
            $display("FAIL en_drop: sample %0d got %b expected %b, empty %b expected 0", fd, lo[fd], e_out[fd], empty);
        end
        void'(q_acc.pop_front());
        void'(q_podd.pop_front());
        build_exp(1, DB, 1, 1);
        @(posedge clk); #1;
        en = 1'b1;
        capture(1'b0, 1 + L1 + 8);
        n_checks++;
        if (lo !== e_out || empty !== 1'b1) begin
            n_fail++; fd = first_diff(lo, e_out);
            $display("FAIL en_resume: sample %0d got %b expected %b, empty %b expected 1", fd, lo[fd], e_out[fd], empty);
        end
    endtask

    task automatic test_stop2;
        int fd;
        q_wr.delete();
        for (int i = 0; i < 2; i++) q_wr.push_back(9'($urandom_range(0, 31)));
        accept_model(2);
        build_exp(1, 5, 2, q_acc.size());
        run_frames(1'b1, 2, 1 + 2 * L2 + 8);
        n_checks++;
        if (lo !== e_out) begin
            n_fail++; fd = first_diff(lo, e_out);
            $display("FAIL stop2_out: sample %0d got %b expected %b", fd, lo[fd], e_out[fd]);
        end
        n_checks++;
        if (lb !== e_busy || ld !== e_done) begin
            n_fail++; fd = first_diff(ld, e_done);
            $display("FAIL stop2_busy_done: busy ok %b, done sample %0d got %b expected %b",
                     lb === e_busy, fd, ld[fd], e_done[fd]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_enable();
        test_stop2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
